rib_arbiter_ctrl: RTL and testbench

Sequencing and arbitration controller for the shared RIB interconnect. It arbitrates four masters onto one slave port:
- m0: core load/store
- m1: instruction fetch
- m2: JTAG
- m3: UART download

It decodes the target slave from the address. It stalls the core pipeline through hold_flag_o. For slaves that answer with a req/ack handshake (e.g. i2c at slave 7), it locks the grant until the ack arrives. The RIB datapath muxes are steered by grant_o and slv_sel_o.

---
 rtl/rib_arbiter_ctrl_pkg.sv | 45 ++++
 rtl/rib_prio_enc.sv | 22 ++
 rtl/rib_arbiter_ctrl.sv | 154 +++++++++++++++
 tb/tb_rib_arbiter_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rib_arbiter_ctrl_pkg.sv
// ============================================================================
// rib_arbiter_ctrl_pkg : shared RIB arbiter master indices, FSM states, decode
// Revision: 1.0
// ============================================================================
`default_nettype none

package rib_arbiter_ctrl_pkg;

  localparam int SLV_IDX_W = 4;

  localparam logic [1:0] M_CORE  = 2'd0;
  localparam logic [1:0] M_FETCH = 2'd1;
  localparam logic [1:0] M_JTAG  = 2'd2;
  localparam logic [1:0] M_UART  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } rib_state_e;

  // Indices 8..15 address no physical slave and select nothing.
  function automatic logic [7:0] slv_decode(input logic [SLV_IDX_W-1:0] idx);
    logic [7:0] dec;
    dec = 8'h00;
    if (!idx[3]) dec[idx[2:0]] = 1'b1;
    return dec;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = M_FETCH;
    case (oh)
      4'b0001: idx = M_CORE;
      4'b0010: idx = M_FETCH;
      4'b0100: idx = M_JTAG;
      4'b1000: idx = M_UART;
      default: idx = M_FETCH;
    endcase
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rib_prio_enc.sv
// ============================================================================
// rib_prio_enc : 4-request fixed-priority encoder (3 > 0 > 2 > 1), one-hot out
// Revision: 1.0
// ============================================================================
`default_nettype none

module rib_prio_enc (
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o
);

  // Master 1 is the default owner, so it wins even with no request pending.
  always_comb begin
    gnt_o = 4'b0010;
    if (req_i[3])      gnt_o = 4'b1000;
    else if (req_i[0]) gnt_o = 4'b0001;
    else if (req_i[2]) gnt_o = 4'b0100;
  end

endmodule

`default_nettype wire

// File: rtl/rib_arbiter_ctrl.sv
// ============================================================================
// rib_arbiter_ctrl : RIB 4-master arbiter, slave decode, handshake lock, hold
// Optional ack timeout enabled by defining RIB_ACK_TIMEOUT_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module rib_arbiter_ctrl
  import rib_arbiter_ctrl_pkg::*;
#(
  parameter int         ADDR_W         = 32,
  parameter logic [7:0] WAIT_SLV_MASK  = 8'h80,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          m_req_i,
  input  logic [3:0]          m_we_i,
  input  logic [4*ADDR_W-1:0] m_addr_i,
  input  logic                slv_ack_i,
  output logic [3:0]          grant_o,
  output logic [7:0]          slv_sel_o,
  output logic                slv_we_o,
  output logic                slv_req_o,
  output logic [3:0]          m_ack_o,
  output logic                hold_flag_o,
  output logic                err_o
);

  rib_state_e           state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic [SLV_IDX_W-1:0] slv_q, slv_d;

  logic [SLV_IDX_W-1:0] m_slv [4];
  logic [3:0]           win_gnt;
  logic [1:0]           win_idx;
  logic [SLV_IDX_W-1:0] win_slv;
  logic                 win_valid;
  logic                 win_wait;
  logic [3:0]           own_gnt;
  logic                 expire;

  for (genvar n = 0; n < 4; n++) begin : g_slv
    assign m_slv[n] = m_addr_i[n*ADDR_W + ADDR_W - SLV_IDX_W +: SLV_IDX_W];
  end

  rib_prio_enc u_prio (
    .req_i (m_req_i),
    .gnt_o (win_gnt)
  );

  assign win_idx   = onehot_to_idx(win_gnt);
  assign win_slv   = m_slv[win_idx];
  assign win_valid = |(m_req_i & win_gnt);
  assign win_wait  = WAIT_SLV_MASK[win_slv[2:0]] & ~win_slv[3];
  assign own_gnt   = 4'(1) << owner_q;

`ifdef RIB_ACK_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign expire = (state_q == ST_WAIT) && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE)      cnt_d = 8'd0;
    else if (state_q == ST_WAIT) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    slv_d       = slv_q;
    grant_o     = win_gnt;
    slv_sel_o   = slv_decode(win_slv);
    slv_req_o   = 1'b0;
    m_ack_o     = 4'b0000;
    hold_flag_o = 1'b0;
    err_o       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        hold_flag_o = (win_gnt != 4'b0010);
        if (win_valid) begin
          if (win_wait) begin
            slv_req_o = 1'b1;
            owner_d   = win_idx;
            slv_d     = win_slv;
            state_d   = ST_WAIT;
          end else begin
            m_ack_o = win_gnt;
          end
        end
      end
      ST_WAIT: begin
        grant_o     = own_gnt;
        slv_sel_o   = slv_decode(slv_q);
        slv_req_o   = 1'b1;
        hold_flag_o = 1'b1;
        // A real ack takes precedence over a simultaneous timeout.
        if (slv_ack_i) begin
          m_ack_o = own_gnt;
          state_d = ST_DONE;
        end else if (expire) begin
          m_ack_o = own_gnt;
          err_o   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        grant_o     = own_gnt;
        slv_sel_o   = slv_decode(slv_q);
        hold_flag_o = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // While reset is held the outputs present the reset-state view.
    if (rst) begin
      grant_o     = 4'b0010;
      slv_sel_o   = slv_decode(m_slv[1]);
      slv_req_o   = 1'b0;
      m_ack_o     = 4'b0000;
      hold_flag_o = 1'b0;
      err_o       = 1'b0;
    end
  end

  assign slv_we_o = |(m_we_i & grant_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= M_FETCH;
      slv_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      slv_q   <= slv_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rib_arbiter_ctrl.sv
// ============================================================================
// tb_rib_arbiter_ctrl : directed vector table plus handshake/lock/reset sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rib_arbiter_ctrl;

  logic         clk;
  logic         rst;
  logic [3:0]   m_req_i;
  logic [3:0]   m_we_i;
  logic [31:0]  a0, a1, a2, a3;
  logic [127:0] m_addr_i;
  logic         slv_ack_i;
  logic [3:0]   grant_o;
  logic [7:0]   slv_sel_o;
  logic         slv_we_o;
  logic         slv_req_o;
  logic [3:0]   m_ack_o;
  logic         hold_flag_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;

  assign m_addr_i = {a3, a2, a1, a0};

  rib_arbiter_ctrl #(
    .ADDR_W         (32),
    .WAIT_SLV_MASK  (8'h80),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (m_req_i),
    .m_we_i      (m_we_i),
    .m_addr_i    (m_addr_i),
    .slv_ack_i   (slv_ack_i),
    .grant_o     (grant_o),
    .slv_sel_o   (slv_sel_o),
    .slv_we_o    (slv_we_o),
    .slv_req_o   (slv_req_o),
    .m_ack_o     (m_ack_o),
    .hold_flag_o (hold_flag_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] addr3;
    logic        ack;
    logic [3:0]  e_gnt;
    logic [7:0]  e_sel;
    logic        e_we;
    logic [3:0]  e_ack;
    logic        e_hold;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 2 ns later.
  task automatic drive_edge();
    @(negedge clk);
  endtask

  task automatic hs_state(input string nm, input logic e_req, input logic [3:0] e_ack,
                          input logic [3:0] e_gnt, input logic e_err);
    chk({nm, " slv_req"}, 32'(slv_req_o), 32'(e_req));
    chk({nm, " m_ack"}, 32'(m_ack_o), 32'(e_ack));
    chk({nm, " grant"}, 32'(grant_o), 32'(e_gnt));
    chk({nm, " hold"}, 32'(hold_flag_o), 32'd1);
    chk({nm, " err"}, 32'(err_o), 32'(e_err));
  endtask

  initial begin
    //              req      we       addr3          ack   gnt      sel     we    ack      hold
    vecs[0] = '{4'b0000, 4'b0000, 32'h3000_0000, 1'b0, 4'b0010, 8'h01, 1'b0, 4'b0000, 1'b0};
    vecs[1] = '{4'b0010, 4'b0010, 32'h3000_0000, 1'b0, 4'b0010, 8'h01, 1'b1, 4'b0010, 1'b0};
    vecs[2] = '{4'b0001, 4'b0000, 32'h3000_0000, 1'b0, 4'b0001, 8'h02, 1'b0, 4'b0001, 1'b1};
    vecs[3] = '{4'b1101, 4'b1000, 32'h3000_0000, 1'b1, 4'b1000, 8'h08, 1'b1, 4'b1000, 1'b1};
    vecs[4] = '{4'b0101, 4'b0001, 32'h3000_0000, 1'b0, 4'b0001, 8'h02, 1'b1, 4'b0001, 1'b1};
    vecs[5] = '{4'b0100, 4'b0100, 32'h3000_0000, 1'b0, 4'b0100, 8'h04, 1'b1, 4'b0100, 1'b1};
    vecs[6] = '{4'b0110, 4'b0010, 32'h3000_0000, 1'b1, 4'b0100, 8'h04, 1'b0, 4'b0100, 1'b1};
    vecs[7] = '{4'b1010, 4'b0010, 32'h3000_0000, 1'b0, 4'b1000, 8'h08, 1'b0, 4'b1000, 1'b1};
    vecs[8] = '{4'b1000, 4'b0000, 32'hF000_0000, 1'b0, 4'b1000, 8'h00, 1'b0, 4'b1000, 1'b1};

    rst = 1'b1; m_req_i = 4'b0000; m_we_i = 4'b0000; slv_ack_i = 1'b0;
    a0 = 32'h1000_0004; a1 = 32'h0000_0000; a2 = 32'h2000_0000; a3 = 32'h3000_0000;

    // Reset state
    drive_edge(); drive_edge(); #2;
    chk("rst grant", 32'(grant_o), 32'h2);
    chk("rst sel", 32'(slv_sel_o), 32'h01);
    chk("rst slv_req", 32'(slv_req_o), 32'd0);
    chk("rst hold", 32'(hold_flag_o), 32'd0);
    chk("rst m_ack", 32'(m_ack_o), 32'd0);
    chk("rst err", 32'(err_o), 32'd0);
    drive_edge(); rst = 1'b0;

    // Zero-wait arbitration table
    for (int i = 0; i < 9; i++) begin
      drive_edge();
      m_req_i = vecs[i].req; m_we_i = vecs[i].we; a3 = vecs[i].addr3; slv_ack_i = vecs[i].ack;
      #2;
      chk($sformatf("v%0d grant", i), 32'(grant_o), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d sel", i), 32'(slv_sel_o), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d we", i), 32'(slv_we_o), 32'(vecs[i].e_we));
      chk($sformatf("v%0d m_ack", i), 32'(m_ack_o), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d hold", i), 32'(hold_flag_o), 32'(vecs[i].e_hold));
      chk($sformatf("v%0d slv_req", i), 32'(slv_req_o), 32'd0);
      chk($sformatf("v%0d err", i), 32'(err_o), 32'd0);
    end

    // Handshake slave 7 with a 5-cycle ack delay; m3 arrives mid-WAIT (lock)
    drive_edge();
    a3 = 32'h3000_0000; a0 = 32'h7000_0000; m_we_i = 4'b0001; m_req_i = 4'b0001; slv_ack_i = 1'b0;
    #2;
    hs_state("hs idle", 1'b1, 4'b0000, 4'b0001, 1'b0);
    chk("hs idle sel", 32'(slv_sel_o), 32'h80);
    chk("hs idle we", 32'(slv_we_o), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      drive_edge();
      if (c == 2) m_req_i = 4'b1001;
      #2;
      hs_state($sformatf("hs wait%0d", c), 1'b1, 4'b0000, 4'b0001, 1'b0);
      chk($sformatf("hs wait%0d sel", c), 32'(slv_sel_o), 32'h80);
    end
    drive_edge(); slv_ack_i = 1'b1; #2;
    hs_state("hs ack", 1'b1, 4'b0001, 4'b0001, 1'b0);
    drive_edge(); m_req_i = 4'b1000; #2;
    hs_state("hs done", 1'b0, 4'b0000, 4'b0001, 1'b0);
    chk("hs done sel", 32'(slv_sel_o), 32'h80);
    drive_edge(); slv_ack_i = 1'b0; #2;
    chk("hs after grant", 32'(grant_o), 32'h8);
    chk("hs after m_ack", 32'(m_ack_o), 32'h8);
    chk("hs after sel", 32'(slv_sel_o), 32'h08);

    // Unanswered handshake
    drive_edge(); m_req_i = 4'b0001; m_we_i = 4'b0000; #2;
    chk("na idle slv_req", 32'(slv_req_o), 32'd1);
`ifdef RIB_ACK_TIMEOUT_EN
    for (int c = 1; c <= 3; c++) begin
      drive_edge(); #2;
      hs_state($sformatf("to wait%0d", c), 1'b1, 4'b0000, 4'b0001, 1'b0);
    end
    drive_edge(); m_req_i = 4'b0000; #2;
    hs_state("to expire", 1'b1, 4'b0001, 4'b0001, 1'b1);
    drive_edge(); #2;
    hs_state("to done", 1'b0, 4'b0000, 4'b0001, 1'b0);
    drive_edge(); #2;
    chk("to idle grant", 32'(grant_o), 32'h2);
    chk("to idle hold", 32'(hold_flag_o), 32'd0);
    // Ack coinciding with expiry: ack wins, no error
    drive_edge(); m_req_i = 4'b0001; #2;
    for (int c = 1; c <= 3; c++) drive_edge();
    drive_edge(); slv_ack_i = 1'b1; #2;
    hs_state("to ackwin", 1'b1, 4'b0001, 4'b0001, 1'b0);
    drive_edge(); slv_ack_i = 1'b0; m_req_i = 4'b0000;
    drive_edge();
    drive_edge(); m_req_i = 4'b0001; #2;
    drive_edge(); #2;
`else
    for (int c = 1; c <= 10; c++) drive_edge();
    #2;
    hs_state("na wait10", 1'b1, 4'b0000, 4'b0001, 1'b0);
`endif
    chk("mid wait slv_req", 32'(slv_req_o), 32'd1);

    // Reset mid-WAIT: no ack, back to IDLE
    drive_edge(); rst = 1'b1; m_req_i = 4'b0000; slv_ack_i = 1'b1; #2;
    chk("rstw m_ack", 32'(m_ack_o), 32'd0);
    chk("rstw slv_req", 32'(slv_req_o), 32'd0);
    drive_edge(); rst = 1'b0; slv_ack_i = 1'b0; #2;
    chk("rstw idle grant", 32'(grant_o), 32'h2);
    chk("rstw idle slv_req", 32'(slv_req_o), 32'd0);
    chk("rstw idle hold", 32'(hold_flag_o), 32'd0);
    drive_edge(); a0 = 32'h1000_0004; m_req_i = 4'b0001; #2;
    chk("rstw zw m_ack", 32'(m_ack_o), 32'h1);
    chk("rstw zw sel", 32'(slv_sel_o), 32'h02);

    drive_edge(); m_req_i = 4'b0000;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
